mips_regfile_wb: RTL

MIPS_REGFILE_WB -- requirements
Module: mips_regfile_wb

---
 rtl/mips_regfile_wb.sv | 102 ++++++++++
 1 files changed

// File: rtl/mips_regfile_wb.sv
// MIPS 32x32 register file with WB-stage write port, two combinational ID read ports,
// a post-reset clearing sweep and write bookkeeping. Optional macro: REGFILE_BYPASS_EN.
module mips_regfile_wb (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write_WB,
   input  logic [4:0]  write_register_addr_WB,
   input  logic [31:0] write_back_data_WB,
   input  logic [4:0]  read_addr1_ID,
   input  logic [4:0]  read_addr2_ID,
   output logic [31:0] read_data1_ID,
   output logic [31:0] read_data2_ID,
   output logic        rf_ready,
   output logic [31:0] commit_count,
   output logic [4:0]  last_wr_addr,
   output logic [31:0] last_wr_data
);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  clear_idx_q, clear_idx_d;
   logic [31:0] commit_count_q, commit_count_d;
   logic [4:0]  last_wr_addr_q, last_wr_addr_d;
   logic [31:0] last_wr_data_q, last_wr_data_d;
   logic [31:0] regs_q [32];

   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        wr_accept;

   assign wr_accept = (state_q == RUN) && reg_write_WB && (write_register_addr_WB != 5'd0);

   always_comb begin
      state_d        = state_q;
      clear_idx_d    = clear_idx_q;
      commit_count_d = commit_count_q;
      last_wr_addr_d = last_wr_addr_q;
      last_wr_data_d = last_wr_data_q;
      mem_we         = 1'b0;
      mem_waddr      = clear_idx_q;
      mem_wdata      = 32'd0;
      // Reset only rewinds the sweep; storage itself is zeroed by the INIT cycles that follow.
      if (!reset) begin
         state_d        = INIT;
         clear_idx_d    = 5'd0;
         commit_count_d = 32'd0;
         last_wr_addr_d = 5'd0;
         last_wr_data_d = 32'd0;
      end else begin
         case (state_q)
            INIT: begin
               mem_we      = 1'b1;
               mem_waddr   = clear_idx_q;
               mem_wdata   = 32'd0;
               clear_idx_d = clear_idx_q + 5'd1;
               if (clear_idx_q == 5'd31) state_d = RUN;
            end
            RUN: begin
               if (wr_accept) begin
                  mem_we         = 1'b1;
                  mem_waddr      = write_register_addr_WB;
                  mem_wdata      = write_back_data_WB;
                  commit_count_d = commit_count_q + 32'd1;
                  last_wr_addr_d = write_register_addr_WB;
                  last_wr_data_d = write_back_data_WB;
               end
            end
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q        <= state_d;
      clear_idx_q    <= clear_idx_d;
      commit_count_q <= commit_count_d;
      last_wr_addr_q <= last_wr_addr_d;
      last_wr_data_q <= last_wr_data_d;
      if (mem_we) regs_q[mem_waddr] <= mem_wdata;
   end

   function automatic logic [31:0] read_port(input logic [4:0] addr);
      logic [31:0] val;
      val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
      // Write-first: the WB value overtakes the array in the same cycle.
      if (reg_write_WB && (write_register_addr_WB == addr)) val = write_back_data_WB;
`endif
      if ((state_q != RUN) || (addr == 5'd0)) val = 32'd0;
      return val;
   endfunction

   assign read_data1_ID = read_port(read_addr1_ID);
   assign read_data2_ID = read_port(read_addr2_ID);
   assign rf_ready      = (state_q == RUN);
   assign commit_count  = commit_count_q;
   assign last_wr_addr  = last_wr_addr_q;
   assign last_wr_data  = last_wr_data_q;

endmodule
